instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 185 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//
// Packs decoded control fields and register specifiers into 32-bit instruction
// words, buffers them in a small FIFO, and streams them into an instruction
// memory. The memory address starts at BASE_ADDR, advances by 4 per accepted
// write, and wraps back to BASE_ADDR after MEM_WORDS words.
//
// Optional feature macro: INSTR_ENCODER_CHECK_EN
//   defined   : requests whose control fields are inconsistent with ALU_op_i
//               are dropped and reported with a one-cycle err_o pulse.
//   undefined : every accepted request is encoded and written; only ALU_op_i
//               of the control inputs matters; err_o is tied low.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   encode-request handshake
//   RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, ALU_op_i   control fields
//   rs_i, rt_i, rd_i, funct_i, imm_i                    operand fields
//   mem_we_o, mem_ready_i memory write strobe / memory accept
//   mem_addr_o, mem_data_o byte address and encoded word of the pending write
//   err_o                 one-cycle pulse after a rejected request
//   wrap_o                one-cycle pulse when the address wraps to BASE_ADDR
//   count_o               accepted memory writes, modulo 256

module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        RegWrite_i,
    input  logic        ALUSrc_i,
    input  logic        RegDst_i,
    input  logic        Branch_i,
    input  logic [3:0]  ALU_op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    output logic        mem_we_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        err_o,
    output logic        wrap_o,
    output logic [7:0]  count_o
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [31:0]       LAST_ADDR  = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));

    typedef enum logic [0:0] {
        IDLE,
        WRITE
    } state_t;

    state_t             state;
    logic [5:0]         opcode;
    logic [31:0]        word;
    logic               legal;
    logic               accept;
    logic               push;
    logic               pop;
    logic [31:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   occupancy;
    logic [CNT_W-1:0]   occ_next;

    // Encoding: opcode 0 selects the R-type layout, anything else the I-type one.
    always_comb begin
        opcode = {2'b00, ALU_op_i};
        word   = '0;
        if (opcode == 6'd0) begin
            word = {6'b0, rs_i, rt_i, rd_i, 5'b0, funct_i};
        end else begin
            word = {opcode, rs_i, rt_i, imm_i};
        end
    end

`ifdef INSTR_ENCODER_CHECK_EN
    // Control fields must be the ones implied by the ALU operation.
    assign legal = (Branch_i == ALU_op_i[2]) &&
                   (ALUSrc_i == ALU_op_i[3]) &&
                   (RegWrite_i == ~ALU_op_i[2]) &&
                   (RegDst_i == (ALU_op_i == 4'd0));

    // A rejected request reports itself for exactly the following cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= accept && !legal;
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{RegWrite_i, ALUSrc_i, RegDst_i, Branch_i};
    assign legal       = 1'b1;
    assign err_o       = 1'b0;
`endif

    // Ready looks only at the registered occupancy, so a pop in the same
    // cycle never opens a slot early.
    assign req_ready_o = (occupancy != FULL_COUNT);
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && legal;
    assign pop         = (state == WRITE) && mem_ready_i;
    assign mem_data_o  = fifo_mem[rd_ptr];

    always_comb begin
        occ_next = occupancy;
        if (push && !pop) begin
            occ_next = occupancy + CNT_W'(1);
        end else if (pop && !push) begin
            occ_next = occupancy - CNT_W'(1);
        end
    end

    // Storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= word;
        end
    end

    // Writer FSM plus FIFO pointers. The FIFO head is presented while in
    // WRITE; a stalled memory leaves head and address untouched, so the
    // write data and address stay stable until mem_ready_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occupancy  <= '0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= BASE_ADDR;
            count_o    <= '0;
            wrap_o     <= 1'b0;
        end else begin
            wrap_o    <= 1'b0;
            occupancy <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (occupancy != '0) begin
                        state    <= WRITE;
                        mem_we_o <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ready_i) begin
                        count_o <= count_o + 8'd1;
                        if (mem_addr_o == LAST_ADDR) begin
                            mem_addr_o <= BASE_ADDR;
                            wrap_o     <= 1'b1;
                        end else begin
                            mem_addr_o <= mem_addr_o + 32'd4;
                        end
                        if (occ_next == '0) begin
                            state    <= IDLE;
                            mem_we_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. A vector table carries inputs and
// hand-computed encoded words; accepted requests push their expected word to
// a scoreboard queue, and every memory write pops and compares it together
// with the expected address, count and pulse outputs. Hand-written sequences
// cover latency, back-pressure, address wrap and reset during a stalled write.
// Honours INSTR_ENCODER_CHECK_EN the same way the design does.

module tb_instr_encoder;

    localparam int          DEPTH     = 4;
    localparam int          MEM_WORDS = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] LAST_ADDR = 32'h0000_000C;

    typedef struct {
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] exp_word;
        logic        exp_legal;
    } vec_t;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        RegWrite_i;
    logic        ALUSrc_i;
    logic        RegDst_i;
    logic        Branch_i;
    logic [3:0]  ALU_op_i;
    logic [4:0]  rs_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic        mem_we_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        err_o;
    logic        wrap_o;
    logic [7:0]  count_o;

    int          total_checks = 0;
    int          bad_checks   = 0;
    int          writes_seen  = 0;
    int          wraps_seen   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model_addr;
    logic [7:0]  model_count;
    logic        err_exp;
    logic        wrap_exp;
    logic [31:0] cur_word;
    logic        cur_legal;
    logic        mon_wr;
    logic        mon_acc;

    vec_t        vecs [8];
    int          legal_idx [5];

    instr_encoder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .RegWrite_i  (RegWrite_i),
        .ALUSrc_i    (ALUSrc_i),
        .RegDst_i    (RegDst_i),
        .Branch_i    (Branch_i),
        .ALU_op_i    (ALU_op_i),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .rd_i        (rd_i),
        .funct_i     (funct_i),
        .imm_i       (imm_i),
        .mem_we_o    (mem_we_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .err_o       (err_o),
        .wrap_o      (wrap_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL %s: got timeout, expected completion", name);
    endtask

    // Scoreboard monitor, sampled on the falling edge while inputs are stable.
    // At this point the queue length equals the DUT's registered occupancy.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            model_addr  = BASE_ADDR;
            model_count = 8'd0;
            err_exp     = 1'b0;
            wrap_exp    = 1'b0;
        end else begin
            checkOutput("ready", 32'(req_ready_o), 32'(exp_q.size() < DEPTH));
            checkOutput("err_pulse", 32'(err_o), 32'(err_exp));
            checkOutput("wrap_pulse", 32'(wrap_o), 32'(wrap_exp));
            checkOutput("count", 32'(count_o), 32'(model_count));
            if (wrap_o === 1'b1) wraps_seen++;
            mon_wr = (mem_we_o === 1'b1) && mem_ready_i;
            if (mem_we_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total_checks++;
                    bad_checks++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                             mem_addr_o, mem_data_o);
                end else begin
                    checkOutput("wr_data", mem_data_o, exp_q[0]);
                    checkOutput("wr_addr", mem_addr_o, model_addr);
                end
            end
            wrap_exp = mon_wr && (model_addr == LAST_ADDR);
            if (mon_wr) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                model_addr  = (model_addr == LAST_ADDR) ? BASE_ADDR : model_addr + 32'd4;
                model_count = model_count + 8'd1;
                writes_seen++;
            end
            mon_acc = req_valid_i && (req_ready_o === 1'b1);
            err_exp = mon_acc && !cur_legal;
            if (mon_acc && cur_legal) exp_q.push_back(cur_word);
        end
    end

    // Drive one vector onto the request inputs without waiting.
    task automatic driveVec(input vec_t v);
        ALU_op_i    = v.alu_op;
        RegWrite_i  = v.reg_write;
        ALUSrc_i    = v.alu_src;
        RegDst_i    = v.reg_dst;
        Branch_i    = v.branch;
        rs_i        = v.rs;
        rt_i        = v.rt;
        rd_i        = v.rd;
        funct_i     = v.funct;
        imm_i       = v.imm;
        cur_word    = v.exp_word;
`ifdef INSTR_ENCODER_CHECK_EN
        cur_legal   = v.exp_legal;
`else
        cur_legal   = 1'b1;
`endif
        req_valid_i = 1'b1;
    endtask

    // Offer a request until accepted; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input vec_t v);
        logic accepted;
        accepted = 1'b0;
        driveVec(v);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready_o === 1'b1) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) reportTimeout("accept_timeout");
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst_i = 1'b1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic waitDrain();
        logic drained;
        drained = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && mem_we_o === 1'b0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) reportTimeout("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int w0;
        int wr0;
        int n_legal;

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        RegWrite_i  = 1'b0;
        ALUSrc_i    = 1'b0;
        RegDst_i    = 1'b0;
        Branch_i    = 1'b0;
        ALU_op_i    = 4'h0;
        rs_i        = '0;
        rt_i        = '0;
        rd_i        = '0;
        funct_i     = '0;
        imm_i       = '0;
        cur_word    = '0;
        cur_legal   = 1'b1;

        // alu_op, RegWrite, ALUSrc, RegDst, Branch, rs, rt, rd, funct, imm, word, legal
        vecs[0] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 32'h0022_1820, 1'b1};
        vecs[1] = '{4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4,  5'd5,  5'd0,  6'h00, 16'h0010, 32'h3085_0010, 1'b0};
        vecs[2] = '{4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  5'd8,  5'd0,  6'h00, 16'hBEEF, 32'h10E8_BEEF, 1'b0};
        vecs[3] = '{4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 5'd0,  5'd0,  6'h00, 16'hFFFF, 32'h07E0_FFFF, 1'b1};
        vecs[4] = '{4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  5'd3,  5'd0,  6'h00, 16'h1234, 32'h2043_1234, 1'b1};
        vecs[5] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 5'd16, 5'd17, 5'd0,  6'h00, 16'h8000, 32'h3E11_8000, 1'b1};
        vecs[6] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd31, 6'h3F, 16'hFFFF, 32'h0000_F83F, 1'b1};
        vecs[7] = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1,  5'd1,  5'd1,  6'h01, 16'h0000, 32'h0021_0801, 1'b0};
        legal_idx = '{0, 3, 4, 5, 6};

        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset state.
        checkOutput("reset_ready", 32'(req_ready_o), 32'd1);
        checkOutput("reset_we",    32'(mem_we_o),    32'd0);
        checkOutput("reset_count", 32'(count_o),     32'd0);
        checkOutput("reset_err",   32'(err_o),       32'd0);
        checkOutput("reset_wrap",  32'(wrap_o),      32'd0);

        // First write and its one-cycle latency.
        applyStimulus(vecs[0]);
        checkOutput("lat_idle_we", 32'(mem_we_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_we",   32'(mem_we_o), 32'd1);
        checkOutput("lat_addr", mem_addr_o,    32'h0000_0000);
        checkOutput("lat_data", mem_data_o,    32'h0022_1820);
        waitDrain();
        checkOutput("first_count", 32'(count_o), 32'd1);

        // Table of encodings, back to back with the memory always ready.
        doReset();
        n_legal = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            if (cur_legal) n_legal++;
        end
        waitDrain();
        checkOutput("table_count", 32'(count_o), 32'(n_legal));

        // Back-pressure: memory stalled while five requests are offered.
        doReset();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            driveVec(vecs[legal_idx[i]]);
            @(negedge clk);
            checkOutput("stall_ready", 32'(req_ready_o), (i < 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        w0  = writes_seen;
        wr0 = wraps_seen;
        mem_ready_i = 1'b1;
        waitDrain();
        checkOutput("stall_writes", 32'(writes_seen - w0), 32'd4);
        checkOutput("stall_wraps",  32'(wraps_seen - wr0), 32'd1);

        // Address wrap with five writes into a four-word memory.
        doReset();
        w0  = writes_seen;
        wr0 = wraps_seen;
        for (int i = 0; i < 5; i++) applyStimulus(vecs[legal_idx[i]]);
        waitDrain();
        checkOutput("wrap_writes", 32'(writes_seen - w0), 32'd5);
        checkOutput("wrap_pulses", 32'(wraps_seen - wr0), 32'd1);
        checkOutput("wrap_count",  32'(count_o),          32'd5);
        checkOutput("wrap_addr",   mem_addr_o,            32'h0000_0004);

        // Random memory stalls against a steady request stream.
        doReset();
        fork
            begin
                for (int c = 0; c < 80; c++) begin
                    @(posedge clk);
                    #1 mem_ready_i = 1'($urandom_range(0, 1));
                end
                mem_ready_i = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) applyStimulus(vecs[legal_idx[i % 5]]);
            end
        join
        waitDrain();
        checkOutput("rand_count", 32'(count_o), 32'd12);

        // Reset while a write is stalled with three words buffered.
        doReset();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(vecs[legal_idx[i]]);
        @(posedge clk);
        #1;
        checkOutput("rst_pre_we", 32'(mem_we_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_we",    32'(mem_we_o),    32'd0);
        checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        w0 = writes_seen;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rst_no_writes", 32'(writes_seen - w0), 32'd0);
        checkOutput("rst_count",     32'(count_o),          32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
